// File: rtl/register_scoreboard_pkg.sv
// Shared constants for the register scoreboard: result latencies, stall-reason
// encodings and the pending-count width.
package register_scoreboard_pkg;

    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [CNT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [CNT_W-1:0] LAT_MULT = 3'd4;
    localparam logic [CNT_W-1:0] LAT_DIV  = 3'd7;

    typedef enum logic [1:0] {
        REASON_NONE = 2'b00,
        REASON_RAW  = 2'b01,
        REASON_WAW  = 2'b10,
        REASON_BOTH = 2'b11
    } stallReason_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One pending-result counter: loads a latency on issue, otherwise counts down
// and sticks at zero.
module scoreboard_entry
    import register_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic [CNT_W-1:0] count,
    output logic             nonZero
);

    // A new issue to this register overrides the countdown in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign nonZero = (count != '0);

endmodule

// File: rtl/register_scoreboard.sv
// Issue-stage register scoreboard: detects RAW/WAW hazards against pending
// result latencies, stalls ID, and counts stall cycles.
module register_scoreboard
    import register_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_RegisterRs,
    input  logic [4:0]  ID_RegisterRt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_RegisterRd,
    input  logic [2:0]  ID_Latency,
    output logic        Stall,
    output logic [1:0]  StallReason,
    output logic [31:0] Busy,
    output logic [15:0] StallCycles
);

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      busyBits;
    logic             rsHit;
    logic             rtHit;
    logic             raw;
    logic             waw;
    logic             stall;
    logic             writeEn;
    stallReason_t     reason;

    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // $zero never has a pending write.
    assign cnt[0]      = '0;
    assign busyBits[0] = 1'b0;

    // Hazards look only at registered counts, so an instruction never sees its own update.
    always_comb begin
        rsHit   = ID_UsesRs && (ID_RegisterRs != 5'd0) && (cnt[ID_RegisterRs] != '0);
        rtHit   = ID_UsesRt && (ID_RegisterRt != 5'd0) && (cnt[ID_RegisterRt] != '0);
        raw     = ID_Valid && (rsHit || rtHit);
        waw     = ID_Valid && ID_RegWrite && (ID_RegisterRd != 5'd0)
                  && (cnt[ID_RegisterRd] > ID_Latency);
        stall   = !reset && (raw || waw);
        writeEn = !reset && ID_Valid && !stall && ID_RegWrite;
        reason  = REASON_NONE;
        if (stall) begin
            reason = stallReason_t'({waw, raw});
        end
    end

    for (genvar r = 1; r < 32; r++) begin : gEntry
        scoreboard_entry uEntry (
            .clk       (clk),
            .reset     (reset),
            .load      (writeEn && (ID_RegisterRd == 5'(r))),
            .loadValue (ID_Latency),
            .count     (cnt[r]),
            .nonZero   (busyBits[r])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
        end else if (stall) begin
            StallCycles <= satInc(StallCycles);
        end
    end

    assign Stall       = stall;
    assign StallReason = reason;
    assign Busy        = busyBits;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with a queue-based scoreboard fed by a
// behavioural pending-count model.
module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_Valid;
    logic [4:0]  ID_RegisterRs;
    logic [4:0]  ID_RegisterRt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        ID_RegWrite;
    logic [4:0]  ID_RegisterRd;
    logic [2:0]  ID_Latency;
    logic        Stall;
    logic [1:0]  StallReason;
    logic [31:0] Busy;
    logic [15:0] StallCycles;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        stall;
        logic [1:0]  reason;
        logic [31:0] busy;
        logic [15:0] sc;
    } exp_t;

    exp_t        expQ[$];
    logic [2:0]  mCnt [32];
    logic [15:0] mSc;
    logic [31:0] lastBusy;

    register_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .ID_Valid      (ID_Valid),
        .ID_RegisterRs (ID_RegisterRs),
        .ID_RegisterRt (ID_RegisterRt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .ID_RegWrite   (ID_RegWrite),
        .ID_RegisterRd (ID_RegisterRd),
        .ID_Latency    (ID_Latency),
        .Stall         (Stall),
        .StallReason   (StallReason),
        .Busy          (Busy),
        .StallCycles   (StallCycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int r = 0; r < 32; r++) mCnt[r] = 3'd0;
        mSc = 16'd0;
    endtask

    // One ID cycle: drive at negedge, check before the next posedge, advance the model at it.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uRs, input logic uRt, input logic rw,
                        input logic [4:0] rd, input logic [2:0] lat,
                        output logic obsStall, output logic [1:0] obsReason);
        exp_t e;
        exp_t got;
        logic mRaw;
        logic mWaw;
        @(negedge clk);
        ID_Valid = v; ID_RegisterRs = rs; ID_RegisterRt = rt;
        ID_UsesRs = uRs; ID_UsesRt = uRt; ID_RegWrite = rw;
        ID_RegisterRd = rd; ID_Latency = lat;
        mRaw = v && ((uRs && rs != 5'd0 && mCnt[rs] != 3'd0) ||
                     (uRt && rt != 5'd0 && mCnt[rt] != 3'd0));
        mWaw = v && rw && rd != 5'd0 && (mCnt[rd] > lat);
        e.stall  = mRaw || mWaw;
        e.reason = {mWaw, mRaw};
        e.sc     = mSc;
        for (int r = 0; r < 32; r++) e.busy[r] = (mCnt[r] != 3'd0);
        expQ.push_back(e);
        #1;
        got = expQ.pop_front();
        chk("stall",       32'(Stall),       32'(got.stall));
        chk("reason",      32'(StallReason), 32'(got.reason));
        chk("busy",        Busy,             got.busy);
        chk("stallCycles", 32'(StallCycles), 32'(got.sc));
        obsStall  = Stall;
        obsReason = StallReason;
        lastBusy  = Busy;
        @(posedge clk);
        for (int r = 1; r < 32; r++) begin
            if (v && !e.stall && rw && rd == 5'(r)) mCnt[r] = lat;
            else if (mCnt[r] != 3'd0) mCnt[r] = mCnt[r] - 3'd1;
        end
        if (e.stall && mSc != 16'hFFFF) mSc = mSc + 16'd1;
    endtask

    task automatic idle(input int n);
        logic s;
        logic [1:0] rr;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, s, rr);
    endtask

    // Present one instruction until it issues; returns stall count and last stall reason.
    task automatic runUntilIssue(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uRs, input logic uRt, input logic rw,
                                 input logic [4:0] rd, input logic [2:0] lat,
                                 output int stalls, output logic [1:0] reason);
        logic s;
        logic [1:0] rr;
        logic issued;
        stalls = 0;
        reason = 2'b00;
        issued = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rs, rt, uRs, uRt, rw, rd, lat, s, rr);
            if (!s) begin
                issued = 1'b1;
                break;
            end
            stalls++;
            reason = rr;
        end
        chk("issue_within_budget", 32'(issued), 32'd1);
    endtask

    initial begin
        int n;
        logic [1:0] rsn;
        logic s;

        reset = 1'b1;
        ID_Valid = 1'b1; ID_RegisterRs = 5'd2; ID_RegisterRt = 5'd3;
        ID_UsesRs = 1'b1; ID_UsesRt = 1'b1; ID_RegWrite = 1'b1;
        ID_RegisterRd = 5'd4; ID_Latency = LAT_DIV;
        modelClear();
        #12;
        chk("reset_busy",        Busy,              32'd0);
        chk("reset_stall",       32'(Stall),        32'd0);
        chk("reset_reason",      32'(StallReason),  32'd0);
        chk("reset_stallCycles", 32'(StallCycles),  32'd0);
        ID_Valid = 1'b0;
        #1 reset = 1'b0;

        // Load-use: one stall, RAW reason.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, LAT_LOAD, s, rsn);
        runUntilIssue(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, LAT_ALU, n, rsn);
        chk("loaduse_stalls", 32'(n),   32'd1);
        chk("loaduse_reason", 32'(rsn), 32'(REASON_RAW));
        #1 chk("loaduse_stallCycles", 32'(StallCycles), 32'd1);
        idle(8);

        // ALU chain: no stall, nothing busy.
        step(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, LAT_ALU, s, rsn);
        runUntilIssue(5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd12, LAT_ALU, n, rsn);
        chk("alu_stalls", 32'(n), 32'd0);
        #1 chk("alu_busy", Busy, 32'd0);
        idle(8);

        // Multi-cycle producer: four stalls, Busy[8] clear on the issuing cycle.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, LAT_MULT, s, rsn);
        runUntilIssue(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, LAT_ALU, n, rsn);
        chk("mult_stalls",       32'(n),           32'd4);
        chk("mult_busy8_issue",  32'(lastBusy[8]), 32'd0);
        idle(8);

        // WAW: a fast write behind a slow write to $9.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, LAT_DIV, s, rsn);
        runUntilIssue(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, LAT_ALU, n, rsn);
        chk("waw_stalls", 32'(n),   32'd7);
        chk("waw_reason", 32'(rsn), 32'(REASON_WAW));
        idle(8);

        // $zero is never tracked.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, LAT_DIV, s, rsn);
        runUntilIssue(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd14, LAT_ALU, n, rsn);
        chk("zero_stalls", 32'(n),           32'd0);
        chk("zero_busy0",  32'(lastBusy[0]), 32'd0);
        idle(8);

        // Rs=Rt=Rd: hazard uses counts before this instruction's own load.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd2, s, rsn);
        runUntilIssue(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 3'd3, n, rsn);
        chk("self_stalls1", 32'(n),   32'd2);
        chk("self_reason",  32'(rsn), 32'(REASON_RAW));
        runUntilIssue(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 3'd3, n, rsn);
        chk("self_stalls2", 32'(n), 32'd3);
        idle(8);

        // RAW and WAW together.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 3'd6, s, rsn);
        runUntilIssue(5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, LAT_ALU, n, rsn);
        chk("both_stalls", 32'(n),   32'd6);
        chk("both_reason", 32'(rsn), 32'(REASON_BOTH));
        idle(8);

        // ID_Valid low masks a would-be hazard.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 3'd5, s, rsn);
        step(1'b0, 5'd10, 5'd10, 1'b1, 1'b1, 1'b1, 5'd10, 3'd0, s, rsn);
        chk("novalid_stall",  32'(s),   32'd0);
        chk("novalid_reason", 32'(rsn), 32'd0);
        idle(8);

        // Asynchronous reset between edges discards pending counts.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd3, s, rsn);
        @(negedge clk);
        ID_Valid = 1'b1; ID_RegisterRs = 5'd5; ID_RegisterRt = 5'd0;
        ID_UsesRs = 1'b1; ID_UsesRt = 1'b0; ID_RegWrite = 1'b0;
        ID_RegisterRd = 5'd0; ID_Latency = 3'd0;
        #1 chk("prereset_busy5", 32'(Busy[5]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midreset_busy",        Busy,             32'd0);
        chk("midreset_stall",       32'(Stall),       32'd0);
        chk("midreset_stallCycles", 32'(StallCycles), 32'd0);
        #1 reset = 1'b0;
        modelClear();
        runUntilIssue(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, LAT_ALU, n, rsn);
        chk("postreset_stalls", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
